// File: rtl/sp_pkg.sv
// Shared defaults and command encoding for the stack-pointer unit.
package sp_pkg;
  localparam int unsigned SP_STEP_DEF  = 2;
  localparam logic [15:0] SP_BASE_DEF  = 16'hFFFE;
  localparam logic [15:0] SP_LIMIT_DEF = 16'hFF00;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    LOAD    = 3'd1,
    RESTORE = 3'd2,
    PUSH    = 3'd3,
    POP     = 3'd4
  } sp_cmd_t;

  // Priority: load > restore > single push/pop > hold (push with pop cancels).
  function automatic sp_cmd_t sp_decode(input logic load, input logic restore,
                                        input logic push, input logic pop);
    if (load) begin
      return LOAD;
    end else if (restore) begin
      return RESTORE;
    end else if (push && !pop) begin
      return PUSH;
    end else if (pop && !push) begin
      return POP;
    end else begin
      return HOLD;
    end
  endfunction
endpackage

// File: rtl/sp_frame_lifo.sv
// FRAMES x WIDTH register LIFO holding saved stack-pointer frames.
module sp_frame_lifo #(
  parameter int WIDTH  = 16,
  parameter int FRAMES = 4,
  localparam int CW    = $clog2(FRAMES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [FRAMES];
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(FRAMES));
  assign empty     = (r_count == {CW{1'b0}});
  assign count     = r_count;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty & ~push;

  // Occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= {CW{1'b0}};
    end else if (w_do_push) begin
      r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // Frame storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FRAMES; i++) begin
      if (w_do_push && (r_count == CW'(i))) begin
        r_mem[i] <= din;
      end
    end
  end

  // Top-of-stack read.
  always_comb begin
    dout = {WIDTH{1'b0}};
    for (int i = 0; i < FRAMES; i++) begin
      if (r_count == CW'(i + 1)) begin
        dout = r_mem[i];
      end else begin
        dout = dout;
      end
    end
  end
endmodule

// File: rtl/stack_pointer_unit.sv
// Stack-pointer unit: SP register, push/pop/load/restore, saved-frame LIFO, sticky faults.
// Optional bounds checking is enabled with macro SP_BOUNDS_CHECK_EN.
module stack_pointer_unit
  import sp_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int unsigned      STEP     = SP_STEP_DEF,
  parameter logic [WIDTH-1:0] SP_BASE  = WIDTH'(SP_BASE_DEF),
  parameter logic [WIDTH-1:0] SP_LIMIT = WIDTH'(SP_LIMIT_DEF),
  parameter int               FRAMES   = 4,
  localparam int              CW       = $clog2(FRAMES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp_write,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             push,
  input  logic             pop,
  input  logic             save,
  input  logic             restore,
  input  logic             fault_clr,
  output logic [WIDTH-1:0] sp_out,
  output logic [CW-1:0]    frame_cnt,
  output logic             overflow,
  output logic             underflow,
  output logic             frame_err
);
  if ((STEP == 0) || ((STEP & (STEP - 1)) != 0)) begin : g_bad_step
    $error("STEP must be a power of two");
  end
  if ((SP_LIMIT > SP_BASE) || (FRAMES < 1)) begin : g_bad_cfg
    $error("SP_LIMIT must not exceed SP_BASE and FRAMES must be at least 1");
  end

  logic [WIDTH-1:0] r_sp;
  logic [WIDTH-1:0] w_sp_nxt;
  logic [WIDTH-1:0] w_top;
  logic             w_full, w_empty;
  logic             w_rs_eff, w_conflict, w_lifo_push, w_lifo_pop, w_fe_set;
  logic             r_fe;
  sp_cmd_t          w_cmd;

  // A load swallows a concurrent restore completely; save+restore cancels both on the LIFO.
  assign w_rs_eff    = restore & ~sp_write;
  assign w_conflict  = save & w_rs_eff;
  assign w_lifo_push = save & ~w_conflict & ~w_full;
  assign w_lifo_pop  = w_rs_eff & ~save & ~w_empty;
  assign w_fe_set    = w_conflict | (save & w_full) | (w_rs_eff & ~save & w_empty);
  assign w_cmd       = sp_decode(sp_write, w_rs_eff & ~save, push, pop);

  sp_frame_lifo #(.WIDTH(WIDTH), .FRAMES(FRAMES)) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_lifo_push),
    .pop   (w_lifo_pop),
    .din   (r_sp),
    .dout  (w_top),
    .full  (w_full),
    .empty (w_empty),
    .count (frame_cnt)
  );

`ifdef SP_BOUNDS_CHECK_EN
  logic [WIDTH:0] w_dec, w_inc;
  logic           w_ov_set, w_un_set, r_ov, r_un;

  assign w_dec = {1'b0, r_sp} - (WIDTH+1)'(STEP);
  assign w_inc = {1'b0, r_sp} + (WIDTH+1)'(STEP);

  // Next SP with bounds checks; an out-of-range push/pop holds SP.
  always_comb begin
    w_sp_nxt = r_sp;
    w_ov_set = 1'b0;
    w_un_set = 1'b0;
    case (w_cmd)
      LOAD: begin
        w_sp_nxt = alu_out;
        w_ov_set = (alu_out < SP_LIMIT);
        w_un_set = (alu_out > SP_BASE);
      end
      RESTORE: w_sp_nxt = w_empty ? r_sp : w_top;
      PUSH: begin
        if (w_dec[WIDTH] || (w_dec[WIDTH-1:0] < SP_LIMIT)) begin
          w_ov_set = 1'b1;
        end else begin
          w_sp_nxt = w_dec[WIDTH-1:0];
        end
      end
      POP: begin
        if (w_inc > {1'b0, SP_BASE}) begin
          w_un_set = 1'b1;
        end else begin
          w_sp_nxt = w_inc[WIDTH-1:0];
        end
      end
      default: w_sp_nxt = r_sp;
    endcase
  end

  // Sticky bounds faults; a new fault beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ov <= 1'b0;
      r_un <= 1'b0;
    end else begin
      r_ov <= w_ov_set | (r_ov & ~fault_clr);
      r_un <= w_un_set | (r_un & ~fault_clr);
    end
  end

  assign overflow  = r_ov;
  assign underflow = r_un;
`else
  // Next SP with modulo-2^WIDTH wrap.
  always_comb begin
    w_sp_nxt = r_sp;
    case (w_cmd)
      LOAD:    w_sp_nxt = alu_out;
      RESTORE: w_sp_nxt = w_empty ? r_sp : w_top;
      PUSH:    w_sp_nxt = r_sp - WIDTH'(STEP);
      POP:     w_sp_nxt = r_sp + WIDTH'(STEP);
      default: w_sp_nxt = r_sp;
    endcase
  end

  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // SP and sticky frame-error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= SP_BASE;
      r_fe <= 1'b0;
    end else begin
      r_sp <= w_sp_nxt;
      r_fe <= w_fe_set | (r_fe & ~fault_clr);
    end
  end

  assign sp_out    = r_sp;
  assign frame_err = r_fe;
endmodule

// File: doc/stack_pointer_unit.md
# stack_pointer_unit

Parametrised stack-pointer unit for the accumulator datapath. It holds the processor SP and updates it from explicit push/pop commands or from a direct ALU load. It also keeps a small LIFO of saved SP frames for call/interrupt save and restore, and raises sticky bounds faults. It sits between the control unit (commands) and the ALU/memory address mux (consumes `sp_out`).

## Interface
Parameters:
- `WIDTH`, 16: SP and data width.
- `STEP`, 2: bytes per push/pop. Must be a power of two and less than 2^WIDTH.
- `SP_BASE`, 16'hFFFE: reset value and empty-stack top. The stack grows downward.
- `SP_LIMIT`, 16'hFF00: lowest legal SP.
- `FRAMES`, 4: depth of the saved-frame LIFO, at least 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `sp_write`, in, 1: load SP from `alu_out`.
- `alu_out`, in, WIDTH: load value.
- `push`, in, 1: SP ← SP − STEP.
- `pop`, in, 1: SP ← SP + STEP.
- `save`, in, 1: push the current SP onto the frame LIFO.
- `restore`, in, 1: pop the frame LIFO into SP.
- `fault_clr`, in, 1: clear all sticky faults.
- `sp_out`, out, WIDTH: current SP, registered.
- `frame_cnt`, out, clog2(FRAMES+1): number of occupied frames.
- `overflow`, out, 1: sticky; a push went below SP_LIMIT.
- `underflow`, out, 1: sticky; a pop went above SP_BASE.
- `frame_err`, out, 1: sticky frame error. Set by a save when full, a restore when empty, or save and restore in the same cycle.

## Operation
- **Reset (`reset` = 0, asynchronous):** `sp_out` = SP_BASE, `frame_cnt` = 0, all faults = 0, LIFO contents don't-care.
- **SP update priority:** `sp_write` > `restore` > push/pop > hold.
- **`sp_write`:** SP ← `alu_out`.
- **`restore`:**
  - LIFO not empty: SP ← top entry and `frame_cnt` decrements.
  - LIFO empty: `frame_err` is set and SP is unchanged.
  - When `sp_write` is also high, the restore is ignored entirely: no pop and no error.
- **`push` and `pop` together:** SP is unchanged and no fault is raised.
- **`push` alone:** if SP − STEP < SP_LIMIT (unsigned, including wrap below 0), SP holds and `overflow` is set. Otherwise SP ← SP − STEP.
- **`pop` alone:** if SP + STEP > SP_BASE (including carry out of WIDTH), SP holds and `underflow` is set. Otherwise SP ← SP + STEP.
- **`save`:** stores the pre-update SP value of the same cycle.
  - LIFO full: `frame_err` is set and nothing is stored.
  - `save` and `restore` together: both are suppressed on the LIFO and `frame_err` is set. `sp_write`/push/pop still act.
- **Arithmetic:** WIDTH+1 bit internally so that carry and borrow are detectable. SP is truncated to WIDTH on store.
- **Faults:** sticky until `fault_clr`. A fault raised in the same cycle as `fault_clr` wins and remains set.

## Timing
- All outputs are registered. A command sampled at edge N is visible on `sp_out`, `frame_cnt` and the flags after edge N.
- Latency is one cycle with no stalls. A new command is accepted every cycle.
- Back-to-back save → restore returns the SP saved one cycle earlier.
- Reset asserted mid-operation clears state immediately. Release is synchronised externally by the top level.

## Configuration
- `SP_BOUNDS_CHECK_EN` defined:
  - Push/pop checks apply as above.
  - `sp_write` of a value outside [SP_LIMIT, SP_BASE] still loads, but also sets `overflow` (value below SP_LIMIT) or `underflow` (value above SP_BASE).
- `SP_BOUNDS_CHECK_EN` undefined:
  - No bounds logic is compiled.
  - Push/pop wrap modulo 2^WIDTH.
  - `overflow` and `underflow` are tied to 0.
  - `frame_err` behaviour is unchanged.

## Structure
- **Package `sp_pkg`:** holds the default `SP_BASE`/`SP_LIMIT`/`STEP` constants and a `sp_cmd_t` enum (HOLD, LOAD, RESTORE, PUSH, POP) used for priority decode.
- **Sub-module `sp_frame_lifo`:** parametrised FRAMES×WIDTH register LIFO with push/pop/full/empty/count, all under the same `clk` and `reset`.
- **Top level:** priority decode, SP arithmetic and fault flags.

## Test plan
All scenarios use WIDTH=16, STEP=2, SP_BASE=FFFE, SP_LIMIT=FF00, FRAMES=4, with the macro defined unless stated.
1. **Reset and push/pop:** reset → `sp_out`=FFFE; push ×3 → FFF8; pop → FFFA; push and pop together → FFFA with no fault.
2. **Underflow:** pop at FFFE → `sp_out` stays FFFE and `underflow`=1. `fault_clr` → 0. `fault_clr` together with another pop at FFFE → `underflow` stays 1.
3. **Overflow:** load FF00, then push → `sp_out` stays FF00 and `overflow`=1. A load of FE00 → `sp_out`=FE00 and `overflow`=1.
4. **Frames:**
   - save at FFFE, push, save at FFFC, push to FFFA.
   - restore → FFFC, `frame_cnt`=1; restore → FFFE, `frame_cnt`=0.
   - A third restore → `frame_err`=1, `sp_out`=FFFE.
5. **Frame conflicts:**
   - Five saves → `frame_cnt`=4 and `frame_err`=1.
   - save and restore together → `frame_cnt` unchanged, `frame_err`=1.
   - restore together with load 1234 → `sp_out`=1234, `frame_cnt` unchanged.
6. **Macro undefined:** pop at FFFE → `sp_out`=0000 (wrap), `underflow`=0. Reset asserted mid-sequence → `sp_out`=FFFE immediately, without waiting for a clock edge.
